// File: rtl/hood_state_controller_if.sv
// Button/tick inputs and state outputs of the range-hood master FSM.
// The master modport belongs to whoever drives the buttons; the slave modport belongs to the controller.
interface hood_state_controller_if;
    logic       tick_1hz;
    logic       btn_power;
    logic       btn_menu;
    logic       btn_level1;
    logic       btn_level2;
    logic       btn_level3;
    logic       btn_clean;
    logic [2:0] state;
    logic [7:0] sec_left;
    logic       state_chg;

    modport master (
        output tick_1hz, btn_power, btn_menu, btn_level1, btn_level2, btn_level3, btn_clean,
        input  state, sec_left, state_chg
    );

    modport slave (
        input  tick_1hz, btn_power, btn_menu, btn_level1, btn_level2, btn_level3, btn_clean,
        output state, sec_left, state_chg
    );
endinterface

// File: rtl/hood_state_controller.sv
// Range-hood master FSM: button pulses and 1 Hz tick -> operating state and seconds remaining.
// Optional macro THIRD_ONCE_EN limits THIRD_LEVEL to one entry per power-on.
module hood_state_controller #(
    parameter int unsigned THIRD_SECS = 60,
    parameter int unsigned CLEAN_SECS = 180,
    parameter int unsigned WAIT_SECS  = 60
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hood_state_controller_if.slave   bus
);
    localparam int unsigned SEC_W = 8;
    localparam logic [SEC_W-1:0] THIRD_LD = SEC_W'(THIRD_SECS);
    localparam logic [SEC_W-1:0] CLEAN_LD = SEC_W'(CLEAN_SECS);
    localparam logic [SEC_W-1:0] WAIT_LD  = SEC_W'(WAIT_SECS);

    typedef enum logic [2:0] {
        S_OFF     = 3'b000,
        S_STANDBY = 3'b001,
        S_MODE    = 3'b010,
        S_FIRST   = 3'b011,
        S_SECOND  = 3'b100,
        S_THIRD   = 3'b101,
        S_CLEAN   = 3'b110,
        S_WAIT    = 3'b111
    } state_e;

    state_e           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             chg_q;
    logic             level3_ok;

`ifdef THIRD_ONCE_EN
    logic third_used, third_used_d;

    // Remembers a THIRD_LEVEL visit until the hood is switched off.
    always_comb begin
        third_used_d = third_used;
        if (state_d == S_OFF)
            third_used_d = 1'b0;
        else if (state_d == S_THIRD)
            third_used_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) third_used <= 1'b0;
        else        third_used <= third_used_d;
    end

    assign level3_ok = !third_used;
`else
    assign level3_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            sec_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            chg_q   <= (state_d != state_q);
        end
    end

    // Power first, then per-state button priority menu > clean > level3 > level2 > level1, then expiry.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        if (bus.btn_power) begin
            state_d = (state_q == S_OFF) ? S_STANDBY : S_OFF;
            sec_d   = '0;
        end else begin
            case (state_q)
                S_OFF: ;
                S_STANDBY: begin
                    if (bus.btn_menu) state_d = S_MODE;
                end
                S_MODE: begin
                    if (bus.btn_menu) begin
                        state_d = S_STANDBY;
                    end else if (bus.btn_clean) begin
                        state_d = S_CLEAN;
                        sec_d   = CLEAN_LD;
                    end else if (bus.btn_level3 && level3_ok) begin
                        state_d = S_THIRD;
                        sec_d   = THIRD_LD;
                    end else if (bus.btn_level2) begin
                        state_d = S_SECOND;
                    end else if (bus.btn_level1) begin
                        state_d = S_FIRST;
                    end
                end
                S_FIRST, S_SECOND: begin
                    if (bus.btn_menu)        state_d = S_STANDBY;
                    else if (bus.btn_level2) state_d = S_SECOND;
                    else if (bus.btn_level1) state_d = S_FIRST;
                end
                S_THIRD: begin
                    if (bus.btn_menu) begin
                        state_d = S_WAIT;
                        sec_d   = WAIT_LD;
                    end else if (bus.tick_1hz) begin
                        if (sec_q == SEC_W'(1)) begin
                            state_d = S_SECOND;
                            sec_d   = '0;
                        end else if (sec_q != '0) begin
                            sec_d = sec_q - SEC_W'(1);
                        end
                    end
                end
                S_CLEAN, S_WAIT: begin
                    if (bus.tick_1hz) begin
                        if (sec_q == SEC_W'(1)) begin
                            state_d = S_STANDBY;
                            sec_d   = '0;
                        end else if (sec_q != '0) begin
                            sec_d = sec_q - SEC_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.sec_left  = sec_q;
    assign bus.state_chg = chg_q;
endmodule
